wrr_packet_scheduler: RTL and testbench
=======================================

WRR_PACKET_SCHEDULER -- requirements
Module: wrr_packet_scheduler

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, number of ingress ports (>=2).
REQ-002 SHALL have parameter IDX_WIDTH, default $clog2(N_PORTS), port-index width.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 4, per-port packet-quantum width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, stall limit in cycles (0 = timeout disabled).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port ingress_valid  input  N_PORTS  per-port beat valid.
REQ-008 SHALL have port ingress_last  input  N_PORTS  per-port last beat of packet.
REQ-009 SHALL have port ingress_dst  input  IDX_WIDTH x N_PORTS (unpacked)  per-port destination port ID.
REQ-010 SHALL have port weight  input  WEIGHT_WIDTH x N_PORTS (unpacked)  per-port packets per turn.
REQ-011 SHALL have port egress_port_id  input  IDX_WIDTH  ID of the egress port served.
REQ-012 SHALL have port egress_ready  input  1  egress accepts a beat.
REQ-013 SHALL have port selected_ingress  output  IDX_WIDTH  mux select, registered.
REQ-014 SHALL have port egress_valid  output  1  beat valid to egress.
REQ-015 SHALL have port egress_last  output  1  last beat to egress.
REQ-016 SHALL have port grant  output  N_PORTS  registered one-hot grant (or zero).
REQ-017 SHALL have port ingress_ready  output  N_PORTS  per-port beat accept.
REQ-018 SHALL have port abort  output  1  one-cycle pulse: granted packet dropped by stall timeout.

Function
REQ-019 SHALL implement states IDLE and SEND; a port is "eligible" when ingress_valid[p]=1 and ingress_dst[p]==egress_port_id.
REQ-020 IDLE SHALL search eligible ports starting at rr_ptr, ascending, wrapping modulo N_PORTS (N_PORTS need not be a power of 2); first match is selected.
REQ-021 On a match in IDLE, next cycle SHALL be SEND with select=match, grant one-hot at match; no match keeps IDLE, grant zero.
REQ-022 In IDLE, egress_valid, egress_last and ingress_ready SHALL all be 0 (arbitration costs exactly one cycle).
REQ-023 In SEND, egress_valid=ingress_valid[select], egress_last=ingress_last[select], ingress_ready[select]=egress_ready, other ingress_ready bits 0 (combinational pass-through).
REQ-024 A beat transfers when egress_valid && egress_ready; packet completes on a transfer with egress_last=1.
REQ-025 On entering SEND from a new rr_ptr turn, credit SHALL load weight[select]; weight 0 SHALL load as 1.
REQ-026 On packet completion: credit decrements; if credit after decrement >0 and select is eligible in that same cycle's next beat (ingress_valid[select] && dst match), remain in SEND, grant held (back-to-back packet, zero bubble).
REQ-027 Otherwise on completion: rr_ptr=(select+1) mod N_PORTS, grant cleared, go IDLE.
REQ-028 In SEND, stall counter SHALL count consecutive cycles with ingress_valid[select]=0 and clear on any valid cycle; counter saturates, no wrap.
REQ-029 When stall counter reaches TIMEOUT_CYCLES (nonzero): abort=1 for one cycle, grant cleared, rr_ptr=(select+1) mod N_PORTS, go IDLE.
REQ-030 With TIMEOUT_CYCLES=0, SEND SHALL hold grant indefinitely while ingress_valid[select]=0.
REQ-031 egress_ready low SHALL NOT advance the stall counter and SHALL NOT release the grant.
REQ-032 Changes to weight while in SEND SHALL NOT affect the current credit; sampled only at load.
REQ-033 selected_ingress SHALL equal registered select in all states.

Reset
REQ-034 reset asserted SHALL immediately force state=IDLE, rr_ptr=0, select=0, credit=0, stall counter=0, grant=0, abort=0; combinational outputs then read 0.
REQ-035 reset asserted mid-packet SHALL drop the packet silently (no abort pulse); first arbitration after deassert starts at port 0.

Verification
REQ-036 Ports 0..3 valid to dst 0, weights all 1, single-beat packets, egress_ready=1 -> grant order 0,1,2,3,0, one IDLE cycle between packets.
REQ-037 weight[1]=3, port 1 streams 5 one-beat packets, port 2 also eligible -> port 1 sends 3 back-to-back, then port 2 granted.
REQ-038 Port 2 granted, drops valid for TIMEOUT_CYCLES=8 cycles -> abort pulse on cycle 8, grant=0, next arbitration starts at port 3.
REQ-039 egress_ready held 0 for 20 cycles mid-packet with valid high -> no abort, grant held, no beat lost; completes once ready returns.
REQ-040 N_PORTS=3, rr_ptr at 2, only port 0 eligible -> wrap to port 0; reset asserted mid-packet -> grant=0 same cycle, no abort.

Source files
------------

// File: rtl/wrr_packet_scheduler.sv
// Weighted round-robin packet scheduler for one egress port. It arbitrates
// per packet among the ingress ports and passes the granted port's beats through.
module wrr_packet_scheduler #(
  parameter int N_PORTS        = 4,
  parameter int IDX_WIDTH      = $clog2(N_PORTS),
  parameter int WEIGHT_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_PORTS-1:0]      ingress_valid,
  input  logic [N_PORTS-1:0]      ingress_last,
  input  logic [IDX_WIDTH-1:0]    ingress_dst [N_PORTS],
  input  logic [WEIGHT_WIDTH-1:0] weight [N_PORTS],
  input  logic [IDX_WIDTH-1:0]    egress_port_id,
  input  logic                    egress_ready,
  output logic [IDX_WIDTH-1:0]    selected_ingress,
  output logic                    egress_valid,
  output logic                    egress_last,
  output logic [N_PORTS-1:0]      grant,
  output logic [N_PORTS-1:0]      ingress_ready,
  output logic                    abort
);

  localparam int STALL_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [STALL_W-1:0]   STALL_MAX   = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0]   STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(N_PORTS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                  state_r, state_s;
  logic [IDX_WIDTH-1:0]    rr_ptr_r, rr_ptr_s;
  logic [IDX_WIDTH-1:0]    select_r, select_s;
  logic [WEIGHT_WIDTH-1:0] credit_r, credit_s;
  logic [STALL_W-1:0]      stall_r, stall_s;
  logic [N_PORTS-1:0]      grant_r, grant_s;
  logic                    abort_r, abort_s;

  logic [N_PORTS-1:0]      elig_s;
  logic                    match_found_s;
  logic [IDX_WIDTH-1:0]    match_idx_s;
  logic                    sel_valid_s;
  logic                    sel_last_s;
  logic                    sel_eligible_s;
  logic                    pkt_done_s;
  logic [STALL_W-1:0]      stall_inc_s;

  function automatic logic [N_PORTS-1:0] idx_to_onehot(input logic [IDX_WIDTH-1:0] idx);
    logic [N_PORTS-1:0] oh;
    for (int i = 0; i < N_PORTS; i++) begin
      oh[i] = (IDX_WIDTH'(i) == idx);
    end
    return oh;
  endfunction

  // Ports are not a power of two in general, so wrap explicitly.
  function automatic logic [IDX_WIDTH-1:0] wrap_add(input logic [IDX_WIDTH-1:0] base,
                                                    input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N_PORTS) begin
      sum = sum - N_PORTS;
    end else begin
      sum = sum;
    end
    return IDX_WIDTH'(sum);
  endfunction

  function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] idx);
    return (idx == LAST_IDX) ? {IDX_WIDTH{1'b0}} : idx + IDX_WIDTH'(1);
  endfunction

  // A zero weight still earns one packet per turn.
  function automatic logic [WEIGHT_WIDTH-1:0] load_credit(input logic [WEIGHT_WIDTH-1:0] w);
    return (w == {WEIGHT_WIDTH{1'b0}}) ? WEIGHT_WIDTH'(1) : w;
  endfunction

  // Per-port eligibility: valid beat headed for the served egress port.
  always_comb begin
    elig_s = {N_PORTS{1'b0}};
    for (int p = 0; p < N_PORTS; p++) begin
      elig_s[p] = ingress_valid[p] && (ingress_dst[p] == egress_port_id);
    end
  end

  // Round-robin search starting at rr_ptr; first eligible port wins.
  always_comb begin
    match_found_s = 1'b0;
    match_idx_s   = {IDX_WIDTH{1'b0}};
    for (int i = 0; i < N_PORTS; i++) begin
      if (!match_found_s && elig_s[wrap_add(rr_ptr_r, i)]) begin
        match_found_s = 1'b1;
        match_idx_s   = wrap_add(rr_ptr_r, i);
      end else begin
        match_found_s = match_found_s;
      end
    end
  end

  assign sel_valid_s    = ingress_valid[select_r];
  assign sel_last_s     = ingress_last[select_r];
  assign sel_eligible_s = elig_s[select_r];
  assign pkt_done_s     = (state_r == ST_SEND) && sel_valid_s && egress_ready && sel_last_s;
  assign stall_inc_s    = (stall_r == STALL_MAX) ? stall_r : stall_r + STALL_W'(1);

  // Egress pass-through of the selected port while sending.
  always_comb begin
    egress_valid  = 1'b0;
    egress_last   = 1'b0;
    ingress_ready = {N_PORTS{1'b0}};
    if (state_r == ST_SEND) begin
      egress_valid  = sel_valid_s;
      egress_last   = sel_last_s;
      ingress_ready = idx_to_onehot(select_r) & {N_PORTS{egress_ready}};
    end else begin
      egress_valid  = 1'b0;
      egress_last   = 1'b0;
      ingress_ready = {N_PORTS{1'b0}};
    end
  end

  // Next-state: arbitration, credit accounting and stall timeout.
  always_comb begin
    state_s  = state_r;
    rr_ptr_s = rr_ptr_r;
    select_s = select_r;
    credit_s = credit_r;
    stall_s  = {STALL_W{1'b0}};
    grant_s  = grant_r;
    abort_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (match_found_s) begin
          state_s  = ST_SEND;
          select_s = match_idx_s;
          credit_s = load_credit(weight[match_idx_s]);
          grant_s  = idx_to_onehot(match_idx_s);
        end else begin
          grant_s = {N_PORTS{1'b0}};
        end
      end
      ST_SEND: begin
        if (pkt_done_s) begin
          credit_s = credit_r - WEIGHT_WIDTH'(1);
          // Keep the turn only while credit remains and the next packet is already waiting.
          if ((credit_r > WEIGHT_WIDTH'(1)) && sel_eligible_s) begin
            grant_s = grant_r;
          end else begin
            state_s  = ST_IDLE;
            rr_ptr_s = next_idx(select_r);
            grant_s  = {N_PORTS{1'b0}};
          end
        end else if (!sel_valid_s) begin
          stall_s = stall_inc_s;
          if ((TIMEOUT_CYCLES != 0) && (stall_inc_s == STALL_LIMIT)) begin
            abort_s  = 1'b1;
            state_s  = ST_IDLE;
            rr_ptr_s = next_idx(select_r);
            grant_s  = {N_PORTS{1'b0}};
            stall_s  = {STALL_W{1'b0}};
          end else begin
            abort_s = 1'b0;
          end
        end else begin
          stall_s = {STALL_W{1'b0}};
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = {N_PORTS{1'b0}};
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= {IDX_WIDTH{1'b0}};
      select_r <= {IDX_WIDTH{1'b0}};
      credit_r <= {WEIGHT_WIDTH{1'b0}};
      stall_r  <= {STALL_W{1'b0}};
      grant_r  <= {N_PORTS{1'b0}};
      abort_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      rr_ptr_r <= rr_ptr_s;
      select_r <= select_s;
      credit_r <= credit_s;
      stall_r  <= stall_s;
      grant_r  <= grant_s;
      abort_r  <= abort_s;
    end
  end

  assign selected_ingress = select_r;
  assign grant            = grant_r;
  assign abort            = abort_r;

endmodule

// File: tb/tb_wrr_packet_scheduler.sv
// Directed bench for wrr_packet_scheduler: a 4-port instance with an 8-cycle
// stall limit and a 3-port instance with the timeout disabled.
module tb_wrr_packet_scheduler;

  logic       clk;
  logic       reset;

  logic [3:0] iv4, il4, gnt4, irdy4;
  logic [1:0] dst4 [4];
  logic [3:0] wt4 [4];
  logic [1:0] eport4, sel4;
  logic       erdy4, ev4, el4, abrt4;

  logic [2:0] iv3, il3, gnt3, irdy3;
  logic [1:0] dst3 [3];
  logic [3:0] wt3 [3];
  logic [1:0] eport3, sel3;
  logic       erdy3, ev3, el3, abrt3;

  int n_checks;
  int n_fail;

  wrr_packet_scheduler #(.N_PORTS(4), .WEIGHT_WIDTH(4), .TIMEOUT_CYCLES(8)) dut4 (
    .clk(clk), .reset(reset),
    .ingress_valid(iv4), .ingress_last(il4), .ingress_dst(dst4), .weight(wt4),
    .egress_port_id(eport4), .egress_ready(erdy4),
    .selected_ingress(sel4), .egress_valid(ev4), .egress_last(el4),
    .grant(gnt4), .ingress_ready(irdy4), .abort(abrt4)
  );

  wrr_packet_scheduler #(.N_PORTS(3), .WEIGHT_WIDTH(4), .TIMEOUT_CYCLES(0)) dut3 (
    .clk(clk), .reset(reset),
    .ingress_valid(iv3), .ingress_last(il3), .ingress_dst(dst3), .weight(wt3),
    .egress_port_id(eport3), .egress_ready(erdy3),
    .selected_ingress(sel3), .egress_valid(ev3), .egress_last(el3),
    .grant(gnt3), .ingress_ready(irdy3), .abort(abrt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    iv4 = 4'h0; il4 = 4'h0; eport4 = 2'd0; erdy4 = 1'b1;
    iv3 = 3'h0; il3 = 3'h0; eport3 = 2'd0; erdy3 = 1'b1;
    for (int p = 0; p < 4; p++) begin dst4[p] = 2'd0; wt4[p] = 4'd1; end
    for (int p = 0; p < 3; p++) begin dst3[p] = 2'd0; wt3[p] = 4'd1; end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    iv4 = 4'hF; il4 = 4'hF; iv3 = 3'h7; il3 = 3'h7;
    step();
    step();
    n_checks++;
    if ({gnt4, sel4, ev4, el4, irdy4, abrt4} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_dut4: got %0h expected 0", {gnt4, sel4, ev4, el4, irdy4, abrt4});
    end
    n_checks++;
    if ({gnt3, sel3, ev3, el3, irdy3, abrt3} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_dut3: got %0h expected 0", {gnt3, sel3, ev3, el3, irdy3, abrt3});
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    do_reset();
    iv4 = 4'hF; il4 = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if ({gnt4, ev4, irdy4} !== 9'h000) begin
        n_fail++;
        $display("FAIL rr_idle_%0d: got %0h expected 0", k, {gnt4, ev4, irdy4});
      end
      step();
      exp_g = 4'b0001 << (k % 4);
      n_checks++;
      if ({gnt4, sel4, ev4, el4, irdy4} !== {exp_g, 2'(k % 4), 1'b1, 1'b1, exp_g}) begin
        n_fail++;
        $display("FAIL rr_send_%0d: got %0h expected %0h", k,
                 {gnt4, sel4, ev4, el4, irdy4}, {exp_g, 2'(k % 4), 1'b1, 1'b1, exp_g});
      end
      step();
    end
  endtask

  task automatic test_weighted;
    int xfers;
    do_reset();
    wt4[1] = 4'd3; wt4[2] = 4'd0;
    iv4 = 4'b0110; il4 = 4'b1111;
    xfers = 0;
    #1;
    n_checks++;
    if (gnt4 !== 4'b0000) begin
      n_fail++;
      $display("FAIL wrr_idle: got %0h expected 0", gnt4);
    end
    step();
    wt4[1] = 4'd1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({gnt4, sel4, ev4, irdy4} !== {4'b0010, 2'd1, 1'b1, 4'b0010}) begin
        n_fail++;
        $display("FAIL wrr_b2b_%0d: got %0h expected %0h", k, {gnt4, sel4, ev4, irdy4},
                 {4'b0010, 2'd1, 1'b1, 4'b0010});
      end
      if (ev4 && erdy4) xfers++;
      step();
      #1;
    end
    n_checks++;
    if ({xfers, gnt4, ev4} !== {32'd3, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL wrr_after_quantum: got xfers=%0d grant=%0h ev=%0b expected 3/0/0", xfers, gnt4, ev4);
    end
    step();
    #1;
    n_checks++;
    if ({gnt4, sel4} !== {4'b0100, 2'd2}) begin
      n_fail++;
      $display("FAIL wrr_port2: got %0h expected %0h", {gnt4, sel4}, {4'b0100, 2'd2});
    end
    step();
    #1;
    n_checks++;
    if (gnt4 !== 4'b0000) begin
      n_fail++;
      $display("FAIL wrr_weight0: got %0h expected 0", gnt4);
    end
    step();
    #1;
    n_checks++;
    if (gnt4 !== 4'b0010) begin
      n_fail++;
      $display("FAIL wrr_wrap_to_1: got %0h expected 2", gnt4);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    iv4 = 4'b0100; il4 = 4'b0000;
    #1;
    step();
    iv4 = 4'b0000;
    #1;
    for (int k = 1; k <= 8; k++) begin
      n_checks++;
      if ({gnt4, abrt4, ev4} !== {4'b0100, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL to_hold_%0d: got %0h expected %0h", k, {gnt4, abrt4, ev4}, {4'b0100, 1'b0, 1'b0});
      end
      step();
      #1;
    end
    n_checks++;
    if ({abrt4, gnt4, sel4} !== {1'b1, 4'b0000, 2'd2}) begin
      n_fail++;
      $display("FAIL to_abort: got %0h expected %0h", {abrt4, gnt4, sel4}, {1'b1, 4'b0000, 2'd2});
    end
    iv4 = 4'hF; il4 = 4'hF;
    step();
    #1;
    n_checks++;
    if ({abrt4, gnt4, sel4} !== {1'b0, 4'b1000, 2'd3}) begin
      n_fail++;
      $display("FAIL to_next_port3: got %0h expected %0h", {abrt4, gnt4, sel4}, {1'b0, 4'b1000, 2'd3});
    end
  endtask

  task automatic test_back_pressure;
    int xfers;
    do_reset();
    iv4 = 4'b0001; il4 = 4'b0000; erdy4 = 1'b0;
    xfers = 0;
    #1;
    step();
    #1;
    for (int k = 1; k <= 20; k++) begin
      n_checks++;
      if ({gnt4, ev4, irdy4, abrt4} !== {4'b0001, 1'b1, 4'b0000, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got %0h expected %0h", k, {gnt4, ev4, irdy4, abrt4},
                 {4'b0001, 1'b1, 4'b0000, 1'b0});
      end
      if (ev4 && erdy4) xfers++;
      step();
      #1;
    end
    erdy4 = 1'b1; il4 = 4'b0001;
    #1;
    n_checks++;
    if ({ev4, el4, irdy4, gnt4} !== {1'b1, 1'b1, 4'b0001, 4'b0001}) begin
      n_fail++;
      $display("FAIL bp_release: got %0h expected %0h", {ev4, el4, irdy4, gnt4}, {1'b1, 1'b1, 4'b0001, 4'b0001});
    end
    if (ev4 && erdy4) xfers++;
    step();
    iv4 = 4'b0000;
    #1;
    n_checks++;
    if ({xfers, gnt4, abrt4} !== {32'd1, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_complete: got xfers=%0d grant=%0h abort=%0b expected 1/0/0", xfers, gnt4, abrt4);
    end
  endtask

  task automatic test_wrap_and_reset;
    do_reset();
    iv3 = 3'b010; il3 = 3'b111;
    #1;
    step();
    #1;
    n_checks++;
    if (gnt3 !== 3'b010) begin
      n_fail++;
      $display("FAIL w3_first: got %0h expected 2", gnt3);
    end
    step();
    iv3 = 3'b001; il3 = 3'b000;
    #1;
    step();
    #1;
    n_checks++;
    if ({gnt3, sel3} !== {3'b001, 2'd0}) begin
      n_fail++;
      $display("FAIL w3_wrap: got %0h expected %0h", {gnt3, sel3}, {3'b001, 2'd0});
    end
    iv3 = 3'b000;
    for (int k = 0; k < 20; k++) begin
      step();
      #1;
      n_checks++;
      if ({gnt3, abrt3} !== {3'b001, 1'b0}) begin
        n_fail++;
        $display("FAIL w3_no_timeout_%0d: got %0h expected %0h", k, {gnt3, abrt3}, {3'b001, 1'b0});
      end
    end
    iv3 = 3'b001;
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({gnt3, sel3, ev3, irdy3, abrt3} !== 10'h000) begin
      n_fail++;
      $display("FAIL w3_reset_now: got %0h expected 0", {gnt3, sel3, ev3, irdy3, abrt3});
    end
    step();
    n_checks++;
    if ({gnt3, abrt3} !== 4'h0) begin
      n_fail++;
      $display("FAIL w3_reset_abort: got %0h expected 0", {gnt3, abrt3});
    end
    reset = 1'b0;
    iv3 = 3'b101; il3 = 3'b111;
    step();
    #1;
    n_checks++;
    if ({gnt3, sel3} !== {3'b001, 2'd0}) begin
      n_fail++;
      $display("FAIL w3_after_reset: got %0h expected %0h", {gnt3, sel3}, {3'b001, 2'd0});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_weighted();
    test_timeout();
    test_back_pressure();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
